// File: rtl/metro_pkg.sv
`default_nettype none
// ============================================================================
// Module  : metro_pkg
// Brief   : Shared types, constants and next-station helper for the metro
//           line sequencer. METRO_LOOP_LINE_EN selects a circular line.
// Revision: 1.0 - initial release
// ============================================================================
package metro_pkg;

  localparam int STATION_W = 3;
  localparam logic [STATION_W-1:0] MSG_ESTOP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DWELL   = 3'd1,
    ST_CLOSING = 3'd2,
    ST_TRAVEL  = 3'd3,
    ST_ESTOP   = 3'd4
  } state_e;

  // Station reached from stn when travelling in direction dir.
  function automatic logic [STATION_W-1:0] next_station_f(
    input logic [STATION_W-1:0] stn,
    input logic                 dir,
    input logic [STATION_W-1:0] last_stn
  );
`ifdef METRO_LOOP_LINE_EN
    if (dir && (stn == last_stn)) return '0;
`else
    // Termini clamp so the 3-bit index can never wrap around.
    if (dir && (stn == last_stn)) return stn;
    if (!dir && (stn == '0)) return stn;
`endif
    return dir ? (stn + 1'b1) : (stn - 1'b1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/metro_tick_timer.sv
`default_nettype none
// ============================================================================
// Module  : metro_tick_timer
// Brief   : Phase timer for the sequencer. Load has priority over freeze,
//           freeze over counting; tc flags count == last.
// Revision: 1.0 - initial release
// ============================================================================
module metro_tick_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk_10Hz,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] preset,
  input  logic             count_en,
  input  logic             freeze,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: preset on load, hold while frozen, otherwise advance.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = preset;
    end else if (!freeze && count_en) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_10Hz) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == last);

endmodule
`default_nettype wire

// File: rtl/metro_line_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : metro_line_sequencer
// Brief   : Single-train sequencer: dwell, door-close warning, travel and
//           emergency stop; drives the display message select.
//           Define METRO_LOOP_LINE_EN for a circular (loop) line.
// Revision: 1.0 - initial release
// ============================================================================
module metro_line_sequencer
  import metro_pkg::*;
#(
  parameter int NUM_STATIONS = 6,
  parameter int DWELL_TICKS  = 50,
  parameter int CLOSE_TICKS  = 10,
  parameter int TRAVEL_TICKS = 100,
  parameter int MAX_HOLDS    = 3
) (
  input  logic                 clk_10Hz,
  input  logic                 rst,
  input  logic                 run_en,
  input  logic                 emergency_stop,
  input  logic                 door_hold,
  output logic [STATION_W-1:0] station_idx,
  output logic [STATION_W-1:0] next_station,
  output logic                 direction,
  output logic                 door_open,
  output logic                 moving,
  output logic [STATION_W-1:0] msg_sel,
  output logic                 msg_restart
);

  localparam int MAX_DC    = (DWELL_TICKS > CLOSE_TICKS) ? DWELL_TICKS : CLOSE_TICKS;
  localparam int MAX_TICKS = (MAX_DC > TRAVEL_TICKS) ? MAX_DC : TRAVEL_TICKS;
  localparam int TIMER_W   = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int HOLD_W    = (MAX_HOLDS > 0) ? $clog2(MAX_HOLDS + 1) : 1;

  localparam logic [TIMER_W-1:0]   DWELL_LAST  = TIMER_W'(DWELL_TICKS - 1);
  localparam logic [TIMER_W-1:0]   CLOSE_LAST  = TIMER_W'(CLOSE_TICKS - 1);
  localparam logic [TIMER_W-1:0]   TRAVEL_LAST = TIMER_W'(TRAVEL_TICKS - 1);
  localparam logic [HOLD_W-1:0]    HOLD_LIMIT  = HOLD_W'(MAX_HOLDS);
  localparam logic [STATION_W-1:0] LAST_STN    = STATION_W'(NUM_STATIONS - 1);

  state_e               state_q, state_d, saved_state_q, saved_state_d;
  logic [TIMER_W-1:0]   saved_time_q, saved_time_d;
  logic [STATION_W-1:0] station_q, station_d, next_stn_q, next_stn_d;
  logic                 dir_q, dir_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 door_open_q, door_open_d, moving_q, moving_d;
  logic [STATION_W-1:0] msg_sel_q, msg_sel_d;
  logic                 msg_restart_q, msg_restart_d;

  logic                 t_load, t_en, t_freeze, t_tc;
  logic [TIMER_W-1:0]   t_preset, t_last, t_count;
  logic                 depart_dir;

  // Direction in force for the leg that starts when the dwell ends.
`ifdef METRO_LOOP_LINE_EN
  assign depart_dir = 1'b1;
`else
  assign depart_dir = (station_q == LAST_STN) ? 1'b0 :
                      (station_q == '0)       ? 1'b1 : dir_q;
`endif

  metro_tick_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk_10Hz (clk_10Hz),
    .rst      (rst),
    .load     (t_load),
    .preset   (t_preset),
    .count_en (t_en),
    .freeze   (t_freeze),
    .last     (t_last),
    .count    (t_count),
    .tc       (t_tc)
  );

  // Sequencing: emergency first, then terminal count, then hold/run_en.
  always_comb begin
    state_d       = state_q;
    saved_state_d = saved_state_q;
    saved_time_d  = saved_time_q;
    station_d     = station_q;
    next_stn_d    = next_stn_q;
    dir_d         = dir_q;
    hold_d        = hold_q;
    t_load        = 1'b0;
    t_preset      = '0;
    t_en          = 1'b0;
    t_freeze      = 1'b0;

    case (state_q)
      ST_CLOSING: t_last = CLOSE_LAST;
      ST_TRAVEL:  t_last = TRAVEL_LAST;
      default:    t_last = DWELL_LAST;
    endcase

    case (state_q)
      ST_IDLE: begin
        t_load = 1'b1;
        if (run_en) begin
          state_d = ST_DWELL;
          hold_d  = '0;
        end
      end
      ST_DWELL, ST_CLOSING, ST_TRAVEL: begin
        t_en = 1'b1;
        if (emergency_stop) begin
          // Terminal count pending this cycle is deferred until resume.
          state_d       = ST_ESTOP;
          saved_state_d = state_q;
          saved_time_d  = t_count;
          t_freeze      = 1'b1;
        end else if (t_tc) begin
          t_load = 1'b1;
          if (state_q == ST_DWELL) begin
            if (door_hold && (hold_q < HOLD_LIMIT)) begin
              hold_d = hold_q + 1'b1;
            end else if (!run_en) begin
              // Parked: doors stay open, timer sits on its terminal count.
              t_load   = 1'b0;
              t_freeze = 1'b1;
            end else begin
              state_d    = ST_CLOSING;
              dir_d      = depart_dir;
              next_stn_d = next_station_f(station_q, depart_dir, LAST_STN);
            end
          end else if (state_q == ST_CLOSING) begin
            state_d = ST_TRAVEL;
          end else begin
            state_d   = ST_DWELL;
            station_d = next_stn_q;
            hold_d    = '0;
          end
        end
      end
      ST_ESTOP: begin
        t_freeze = 1'b1;
        if (!emergency_stop) begin
          state_d  = saved_state_q;
          t_load   = 1'b1;
          t_preset = saved_time_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    door_open_d = (state_d == ST_DWELL);
    moving_d    = (state_d == ST_TRAVEL);
    if (state_d == ST_ESTOP) begin
      msg_sel_d = MSG_ESTOP;
    end else if (state_d == ST_TRAVEL) begin
      msg_sel_d = next_stn_d;
    end else begin
      msg_sel_d = station_d;
    end
    // Every state change restarts the scroll except the start of the warning.
    msg_restart_d = (state_d != state_q) &&
                    !((state_q == ST_DWELL) && (state_d == ST_CLOSING));
  end

  // State and registered outputs.
  always_ff @(posedge clk_10Hz) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      saved_state_q <= ST_IDLE;
      saved_time_q  <= '0;
      station_q     <= '0;
      next_stn_q    <= STATION_W'(1);
      dir_q         <= 1'b1;
      hold_q        <= '0;
      door_open_q   <= 1'b0;
      moving_q      <= 1'b0;
      msg_sel_q     <= '0;
      msg_restart_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      saved_state_q <= saved_state_d;
      saved_time_q  <= saved_time_d;
      station_q     <= station_d;
      next_stn_q    <= next_stn_d;
      dir_q         <= dir_d;
      hold_q        <= hold_d;
      door_open_q   <= door_open_d;
      moving_q      <= moving_d;
      msg_sel_q     <= msg_sel_d;
      msg_restart_q <= msg_restart_d;
    end
  end

  assign station_idx  = station_q;
  assign next_station = next_stn_q;
  assign direction    = dir_q;
  assign door_open    = door_open_q;
  assign moving       = moving_q;
  assign msg_sel      = msg_sel_q;
  assign msg_restart  = msg_restart_q;

endmodule
`default_nettype wire
